fetch_queue: RTL and testbench

Decoupling buffer between the instruction-fetch stage and decode in the 32-bit MIPS pipeline. It accepts {pc, instruction} pairs produced each cycle by the program counter and instruction memory, and holds them in a small circular FIFO. It presents the oldest pair to decode under a valid/ready handshake. It drives the PC's stall input when full and discards all wrong-path entries on a taken jump/branch flush.

---
 rtl/fetch_queue_if.sv | 37 +++
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch stage, the fetch queue
// and decode.
//   fetch side : in_valid, in_pc, in_instr -> queue ; stall <- queue
//   control    : flush (taken jump/branch) -> queue
//   decode side: out_valid, out_pc, out_instr <- queue ; out_ready -> queue
//   status     : count (occupancy) <- queue
// Modports:
//   slave  - the queue itself
//   master - whoever drives fetch/decode/flush (pipeline glue or testbench)
interface fetch_queue_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               in_valid;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               stall;
    logic               flush;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;
    logic [CNT_W-1:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  stall, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output stall, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, instruction} pairs decoupling
// instruction fetch from decode.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (priority over flush)
//   bus  - fetch_queue_if.slave: in_valid/in_pc/in_instr/stall on the fetch
//          side, out_valid/out_pc/out_instr/out_ready on the decode side,
//          flush to discard wrong-path entries, count = occupancy.
// Build option:
//   FETCH_QUEUE_BYPASS_EN - when defined, an incoming pair is presented to
//   decode combinationally while the queue is empty and is not stored if
//   decode takes it in the same cycle. Undefined: 1-cycle latency and no
//   input-to-output path.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.slave   bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = PC_W + INSTR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;

    logic               full;
    logic               has_entry;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Full/empty come from the occupancy counter only; pointers are equal in
    // both cases.
    assign full      = (cnt == CNT_W'(DEPTH));
    assign has_entry = (cnt != '0);
    assign head      = mem[rd_ptr];

    // A full queue refuses the push even if decode pops in the same cycle,
    // so stall never depends on out_ready.
    assign pop       = has_entry && bus.out_ready && !bus.flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    logic bypass_take;

    // rst is included so outputs stay at their reset values during reset.
    assign bypass      = !has_entry && bus.in_valid && !bus.flush && !rst;
    // Consumed straight through: never written, count stays 0.
    assign bypass_take = bypass && bus.out_ready;
    assign push        = bus.in_valid && !full && !bus.flush && !bypass_take;

    assign bus.out_valid = has_entry || bypass;

    always_comb begin
        bus.out_pc    = '0;
        bus.out_instr = '0;
        if (has_entry) begin
            bus.out_pc    = head[ENTRY_W-1:INSTR_W];
            bus.out_instr = head[INSTR_W-1:0];
        end else if (bypass) begin
            bus.out_pc    = bus.in_pc;
            bus.out_instr = bus.in_instr;
        end
    end
`else
    assign push          = bus.in_valid && !full && !bus.flush;
    assign bus.out_valid = has_entry;
    assign bus.out_pc    = has_entry ? head[ENTRY_W-1:INSTR_W] : '0;
    assign bus.out_instr = has_entry ? head[INSTR_W-1:0] : '0;
`endif

    assign bus.stall = full;
    assign bus.count = cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            // Array contents are left as-is; count alone defines validity.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized stimulus for fetch_queue, checked
// every cycle against a queue-based reference model of the FIFO rules.
module tb_fetch_queue;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests  = 0;
    int failed = 0;
    bit model_known = 1'b0;
    logic [63:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model's pre-edge state, then advance the model.
    task automatic step(input string tag, input logic r, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic rdy);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        logic        byp;
        @(negedge clk);
        rst          = r;
        bus.in_valid = iv;
        bus.in_pc    = pc;
        bus.in_instr = ins;
        bus.flush    = fl;
        bus.out_ready = rdy;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && iv && !fl && !r;
`endif
        ev   = (q.size() > 0) || byp;
        epc  = (q.size() > 0) ? q[0][63:32] : (byp ? pc  : 32'h0);
        eins = (q.size() > 0) ? q[0][31:0]  : (byp ? ins : 32'h0);
        if (model_known) begin
            chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
            chk({tag, ".out_pc"},    64'(bus.out_pc),    64'(epc));
            chk({tag, ".out_instr"}, 64'(bus.out_instr), 64'(eins));
            chk({tag, ".count"},     64'(bus.count),     64'(q.size()));
            chk({tag, ".stall"},     64'(bus.stall),     64'(q.size() == DEPTH));
        end
        if (r || fl) begin
            q.delete();
        end else if (byp && rdy) begin
            // consumed straight through, nothing stored
        end else begin
            logic do_push;
            do_push = iv && (q.size() < DEPTH);
            if ((q.size() > 0) && rdy) void'(q.pop_front());
            if (do_push) q.push_back({pc, ins});
        end
        if (r) model_known = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with in_valid high, then first push appears next cycle.
        step("rst0", 1, 1, 32'h5, 32'hdead, 0, 0);
        step("rst1", 1, 1, 32'h6, 32'hbeef, 0, 0);
        step("push0", 0, 1, 32'h0, 32'h20010005, 0, 0);
        step("head0", 0, 0, 32'h0, 32'h0, 0, 1);
        step("empty", 0, 0, 32'h0, 32'h0, 0, 0);

        // Fill with decode stalled; pc 4,5 refused, then drain in order.
        for (int i = 0; i < 6; i++)
            step("fill", 0, 1, 32'(i), 32'h1000 + 32'(i), 0, 0);
        for (int i = 0; i < 5; i++)
            step("drain", 0, 0, 32'h0, 32'h0, 0, 1);

        // Streaming past pointer wrap.
        for (int i = 0; i < 20; i++)
            step("stream", 0, 1, 32'(i), 32'h2000 + 32'(i), 0, 1);
        step("stream_end", 0, 0, 32'h0, 32'h0, 0, 1);
        step("stream_idle", 0, 0, 32'h0, 32'h0, 0, 0);

        // Flush with three held entries, concurrent push and pop.
        for (int i = 8; i <= 10; i++)
            step("preflush", 0, 1, 32'(i), 32'h3000 + 32'(i), 0, 0);
        step("flush", 0, 1, 32'd11, 32'h300b, 1, 1);
        step("postflush", 0, 1, 32'h40, 32'h3040, 0, 0);
        step("head40", 0, 0, 32'h0, 32'h0, 0, 0);
        step("pop40", 0, 0, 32'h0, 32'h0, 0, 1);

        // Full with simultaneous push and pop: pop only.
        for (int i = 0; i < 4; i++)
            step("fill2", 0, 1, 32'h50 + 32'(i), 32'h4000 + 32'(i), 0, 0);
        step("fullboth", 0, 1, 32'h99, 32'h4099, 0, 1);
        step("after_full", 0, 0, 32'h0, 32'h0, 0, 0);
        step("flush2", 0, 0, 32'h0, 32'h0, 1, 0);

        // Bypass-shaped stimulus (plain latency when the macro is off).
        step("byp_take", 0, 1, 32'h7, 32'h5007, 0, 1);
        step("byp_idle", 0, 0, 32'h0, 32'h0, 0, 0);
        step("byp_keep", 0, 1, 32'h7, 32'h5007, 0, 0);
        step("byp_held", 0, 0, 32'h0, 32'h0, 0, 1);
        step("byp_done", 0, 0, 32'h0, 32'h0, 0, 0);

        // Randomized traffic with occasional flush and rare reset.
        begin
            logic [31:0] pc_r;
            pc_r = 32'h100;
            for (int i = 0; i < 400; i++) begin
                logic iv, rdy, fl, r;
                iv  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) != 0);
                fl  = ($urandom_range(0, 15) == 0);
                r   = ($urandom_range(0, 63) == 0);
                step("rand", r, iv, pc_r, $urandom, fl, rdy);
                if (iv) pc_r = pc_r + 32'd1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
